fetch_stage: RTL and testbench

Instruction-fetch stage of the single-issue RV32I core. It owns the program counter and drives the address of the combinational `imem` (`addr` → `instruction`, same-cycle read, low two address bits ignored). It captures the returned word together with its PC into the IF/ID pipeline register and hands it to decode with a valid/ready handshake. It handles decode back-pressure, branch/jump redirects and misaligned-target faults.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/if_id_reg.sv | 18 +
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage constants, FSM state type and IF/ID bundle
package riscv_pkg;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          INSTR_BYTES = 4;
   typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_e;
   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with reset, flush (drops valid, keeps payload) and load
// ports: clk, rst_n (sync active-low), i_load, i_flush, i_d (next bundle), o_q (registered bundle)
module if_id_reg
   import riscv_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_load,
   input  logic   i_flush,
   input  if_id_t i_d,
   output if_id_t o_q
);
   always_ff @(posedge clk) begin
      if (!rst_n) o_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      else if (i_flush) o_q.valid <= 1'b0;
      else if (i_load) o_q <= i_d;
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, IF/ID handshake, redirects and misaligned-target fault
// ports: clk, rst_n (sync active-low); imem_addr/imem_instr to the combinational imem;
// redirect_valid/redirect_pc from later stages; id_ready from decode; if_id_* to decode;
// fetch_misaligned/fault_pc fault status; fetch_count instructions accepted by decode
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_id_valid,
   output logic [31:0]     if_id_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic            fetch_misaligned,
   output logic [XLEN-1:0] fault_pc,
   output logic [31:0]     fetch_count
);
   logic [XLEN-1:0] r_pc, r_fault_pc;
   logic [31:0]     r_count;
   fetch_state_e    r_state;
   logic [XLEN-1:0] w_pc_next;
   logic            w_load, w_accept, w_fetch, w_flush;
   if_id_t          w_d, w_q;
   assign w_pc_next = r_pc + XLEN'(INSTR_BYTES);
   assign w_load    = !w_q.valid | id_ready;
   assign w_accept  = w_q.valid & id_ready;
   // a redirect or the fault state always wins over a fetch
   assign w_flush   = redirect_valid | (r_state == FAULT);
   assign w_fetch   = !w_flush & w_load;
   assign w_d       = '{valid: 1'b1, instr: imem_instr, pc: r_pc, pc_plus4: w_pc_next};
   if_id_reg u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_fetch),
      .i_flush (w_flush),
      .i_d     (w_d),
      .o_q     (w_q)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_state    <= RUN;
         r_fault_pc <= '0;
         r_count    <= '0;
      end else begin
         if (w_accept) r_count <= r_count + 32'd1;
         if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
            if (redirect_pc[1:0] != 2'b00) r_fault_pc <= redirect_pc;
         end else if (w_fetch) r_pc <= w_pc_next;
      end
   end
   assign imem_addr        = {r_pc[XLEN-1:2], 2'b00};
   assign if_id_valid      = w_q.valid;
   assign if_id_instr      = w_q.instr;
   assign if_id_pc         = w_q.pc;
   assign if_id_pc_plus4   = w_q.pc_plus4;
   assign fetch_misaligned = (r_state == FAULT);
   assign fault_pc         = r_fault_pc;
   assign fetch_count      = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized checking of fetch_stage against a behavioural model
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr, imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b1;
   logic        if_id_valid, fetch_misaligned;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fault_pc, fetch_count;
   logic [31:0] mem [64];
   int          n_chk = 0, n_err = 0;
   // model state
   bit          m_init = 1'b0;
   logic [31:0] m_pc, m_instr, m_ipc, m_pp4, m_fault_pc, m_count;
   bit          m_valid, m_fault;
   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr[7:2]];
   fetch_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_addr        (imem_addr),
      .imem_instr       (imem_instr),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .id_ready         (id_ready),
      .if_id_valid      (if_id_valid),
      .if_id_instr      (if_id_instr),
      .if_id_pc         (if_id_pc),
      .if_id_pc_plus4   (if_id_pc_plus4),
      .fetch_misaligned (fetch_misaligned),
      .fault_pc         (fault_pc),
      .fetch_count      (fetch_count)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(posedge clk) begin
      if (!rst_n) begin
         m_init = 1'b1; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0000_0013;
         m_ipc = 0; m_pp4 = 0; m_fault = 1'b0; m_fault_pc = 0; m_count = 0;
      end else if (m_init) begin
         if (m_valid && id_ready) m_count = m_count + 1;
         if (redirect_valid) begin
            m_valid = 1'b0;
            m_pc = redirect_pc;
            if (redirect_pc % 4 != 0) begin m_fault = 1'b1; m_fault_pc = redirect_pc; end
            else m_fault = 1'b0;
         end else if (m_fault) m_valid = 1'b0;
         else if (!m_valid || id_ready) begin
            m_valid = 1'b1; m_instr = mem[(m_pc / 4) % 64]; m_ipc = m_pc; m_pp4 = m_pc + 4; m_pc = m_pc + 4;
         end
      end
   end
   always @(negedge clk) begin
      if (m_init) begin
         chk("imem_addr", imem_addr, m_pc & ~32'h3);
         chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
         chk("if_id_instr", if_id_instr, m_instr);
         chk("if_id_pc", if_id_pc, m_ipc);
         chk("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
         chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_fault});
         chk("fault_pc", fault_pc, m_fault_pc);
         chk("fetch_count", fetch_count, m_count);
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h0050_0093; mem[1] = 32'h0060_0113; mem[2] = 32'h0020_81b3; mem[20] = 32'h0000_0013;
      repeat (2) step();
      chk("rst valid", {31'b0, if_id_valid}, 32'd0);
      chk("rst instr", if_id_instr, 32'h0000_0013);
      chk("rst addr", imem_addr, 32'h0);
      rst_n = 1'b1;
      step(); chk("e1 pc", if_id_pc, 32'h0); chk("e1 instr", if_id_instr, 32'h0050_0093);
      step(); chk("e2 pc", if_id_pc, 32'h4); chk("e2 instr", if_id_instr, 32'h0060_0113);
      step(); chk("e3 pc", if_id_pc, 32'h8); chk("e3 instr", if_id_instr, 32'h0020_81b3);
      step(); chk("e4 count", fetch_count, 32'd3);
      rst_n = 1'b0; step();
      chk("rst2 count", fetch_count, 32'd0); chk("rst2 valid", {31'b0, if_id_valid}, 32'd0);
      rst_n = 1'b1; step(); step();
      id_ready = 1'b0;
      repeat (3) begin
         step();
         chk("stall instr", if_id_instr, 32'h0060_0113);
         chk("stall addr", imem_addr, 32'h8);
         chk("stall count", fetch_count, 32'd1);
      end
      id_ready = 1'b1; step();
      chk("release pc", if_id_pc, 32'h8); chk("release instr", if_id_instr, 32'h0020_81b3);
      id_ready = 1'b0; step();
      redirect_valid = 1'b1; redirect_pc = 32'h50; step();
      chk("redir valid", {31'b0, if_id_valid}, 32'd0); chk("redir addr", imem_addr, 32'h50);
      chk("redir count", fetch_count, 32'd2);
      redirect_valid = 1'b0; id_ready = 1'b1; step();
      chk("redir pc", if_id_pc, 32'h50); chk("redir instr", if_id_instr, 32'h0000_0013);
      redirect_valid = 1'b1; redirect_pc = 32'h6; step();
      chk("mis flag", {31'b0, fetch_misaligned}, 32'd1); chk("mis fault_pc", fault_pc, 32'h6);
      chk("mis count", fetch_count, 32'd3);
      redirect_valid = 1'b0;
      repeat (5) begin step(); chk("fault valid", {31'b0, if_id_valid}, 32'd0); end
      redirect_valid = 1'b1; redirect_pc = 32'h0; step();
      chk("unfault flag", {31'b0, fetch_misaligned}, 32'd0);
      redirect_valid = 1'b0; step();
      chk("unfault instr", if_id_instr, 32'h0050_0093);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; step();
      redirect_valid = 1'b0; step();
      chk("wrap pc", if_id_pc, 32'hFFFF_FFFC); chk("wrap pc4", if_id_pc_plus4, 32'h0);
      chk("wrap addr", imem_addr, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h2; step();
      redirect_valid = 1'b0; id_ready = 1'b0; step();
      rst_n = 1'b0; step();
      chk("rstf flag", {31'b0, fetch_misaligned}, 32'd0); chk("rstf fault_pc", fault_pc, 32'h0);
      chk("rstf pc4", if_id_pc_plus4, 32'h0);
      rst_n = 1'b1; id_ready = 1'b1; step();
      chk("rstf resume", if_id_pc, 32'h0);
      for (int i = 0; i < 3000; i++) begin
         id_ready = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc = {24'h0, 6'($urandom), (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00)};
         if ($urandom_range(0, 19) == 0) redirect_pc = 32'hFFFF_FFF0 | {28'h0, 2'($urandom), 2'b00};
         rst_n = ($urandom_range(0, 199) != 0);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
